// File: rtl/fifo_nd_fwft.sv
`default_nettype none
// ============================================================================
// Module      : fifo_nd_fwft
// Description : Synchronous first-word-fall-through FIFO backed by a
//               DEPTH-entry circular buffer. b_data always presents the head
//               entry. With BYPASS=1, an empty FIFO passes a_data straight
//               through to b in the same cycle.
//
// Ports       : clk           - clock, rising-edge active
//               rst           - synchronous active-high reset
//               flush         - synchronous discard of all stored entries
//               a_data/a_valid/a_ready - write side handshake
//               a_almost_full - registered occupancy >= AFULL_THRESH
//               b_data/b_valid/b_ready - read side handshake (FWFT)
//               count         - stored-entry occupancy
//               ovf_err       - sticky: write attempted while full
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_nd_fwft #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 1,
    parameter int BYPASS       = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           a_data,
    input  logic                       a_valid,
    output logic                       a_ready,
    output logic                       a_almost_full,
    output logic [WIDTH-1:0]           b_data,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] c_full_cnt  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_afull_cnt = CNT_W'(AFULL_THRESH);
    localparam logic             c_bypass    = (BYPASS != 0);

    // Storage (not reset) and control state
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              ovf_err_q, ovf_err_d;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_pass;
    logic w_wr_en;
    logic w_rd_adv;

    // ------------------------------------------------------------------------
    // Handshake and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_empty = (count_q == '0);
        w_full  = (count_q == c_full_cnt);

        a_ready = !w_full && !flush;
        b_valid = !flush && (!w_empty || (c_bypass && a_valid));
        b_data  = w_empty ? a_data : mem_q[rd_ptr_q];

        w_push  = a_valid && a_ready;
        w_pop   = b_valid && b_ready;

        // Pass-through: an empty FIFO hands the word directly to b and never
        // stores it. Only reachable with BYPASS=1, since b_valid is low on an
        // empty FIFO otherwise.
        w_pass   = w_empty && w_push && w_pop;
        w_wr_en  = w_push && !w_pass;
        w_rd_adv = w_pop && !w_empty;

        a_almost_full = (count_q >= c_afull_cnt);
        count         = count_q;
        ovf_err       = ovf_err_q;
    end

    // ------------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        ovf_err_d = ovf_err_q;

        if (rst) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            ovf_err_d = 1'b0;
        end else if (flush) begin
            // Flush empties storage but leaves the error flag visible
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap DEPTH-1 -> 0 through natural overflow
            if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (w_rd_adv) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({w_wr_en, w_rd_adv})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (a_valid && w_full) begin
                ovf_err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        rd_ptr_q  <= rd_ptr_d;
        wr_ptr_q  <= wr_ptr_d;
        count_q   <= count_d;
        ovf_err_q <= ovf_err_d;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= a_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_nd_fwft.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_nd_fwft
// Description : Self-checking bench for fifo_nd_fwft. A queue-based reference
//               model tracks expected contents of the BYPASS=1 instance; a
//               second BYPASS=0 instance covers registered-only latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_nd_fwft;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic       a_almost_full;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [2:0] count;
    logic       ovf_err;

    logic [7:0] n_a_data;
    logic       n_a_valid;
    logic       n_a_ready;
    logic       n_a_almost_full;
    logic [7:0] n_b_data;
    logic       n_b_valid;
    logic       n_b_ready;
    logic [2:0] n_count;
    logic       n_ovf_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents in arrival order plus the sticky error flag
    logic [7:0] q[$];
    bit         m_ovf;

    always #5 clk = ~clk;

    fifo_nd_fwft #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .a_almost_full(a_almost_full),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .count(count), .ovf_err(ovf_err)
    );

    fifo_nd_fwft #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .flush(flush),
        .a_data(n_a_data), .a_valid(n_a_valid), .a_ready(n_a_ready),
        .a_almost_full(n_a_almost_full),
        .b_data(n_b_data), .b_valid(n_b_valid), .b_ready(n_b_ready),
        .count(n_count), .ovf_err(n_ovf_err)
    );

    // Advance the model by one clock using the inputs currently applied,
    // then move to the next falling edge where new inputs are driven.
    task automatic tick();
        int sz;
        bit pu;
        bit po;
        sz = q.size();
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (a_valid && sz == 4) m_ovf = 1'b1;
            pu = a_valid && (sz != 4);
            po = b_ready && (sz != 0 || a_valid);
            if (po && sz != 0) void'(q.pop_front());
            if (pu && !(po && sz == 0)) q.push_back(a_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; a_valid = 1'b1; a_data = 8'h33; b_ready = 1'b0;
        tick();
        #1;
        n_tests++;
        if (count !== 3'd0 || ovf_err !== 1'b0 || a_almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d ovf=%b afull=%b, need 0/0/0", count, ovf_err, a_almost_full);
        end
        n_tests++;
        if (a_ready !== 1'b1 || b_valid !== 1'b1 || b_data !== 8'h33) begin
            n_fail++;
            $display("FAIL reset_handshake: a_ready=%b b_valid=%b b_data=%h, need 1/1/33", a_ready, b_valid, b_data);
        end
        a_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        a_valid = 1'b1; a_data = 8'h11; b_ready = 1'b1;
        #1;
        n_tests++;
        if (b_valid !== 1'b1 || b_data !== 8'h11) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: b_valid=%b b_data=%h, need 1/11", b_valid, b_data);
        end
        tick();
        a_valid = 1'b0;
        #1;
        n_tests++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_count: count=%0d, need 0", count);
        end
    endtask

    task automatic test_fill_ovf();
        b_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1'b1; a_data = 8'(i);
            tick();
            #1;
            n_tests++;
            if (a_almost_full !== (i >= 3) || count !== 3'(i)) begin
                n_fail++;
                $display("FAIL fill_%0d: afull=%b count=%0d, need %b/%0d", i, a_almost_full, count, (i >= 3), i);
            end
        end
        n_tests++;
        if (a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_a_ready: a_ready=%b, need 0", a_ready);
        end
        a_data = 8'h05;
        tick();
        a_valid = 1'b0;
        #1;
        n_tests++;
        if (ovf_err !== 1'b1 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b count=%0d, need 1/4", ovf_err, count);
        end
    endtask

    task automatic test_drain();
        a_valid = 1'b0; b_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_tests++;
            if (b_valid !== 1'b1 || b_data !== 8'(i) || b_data !== q[0]) begin
                n_fail++;
                $display("FAIL drain_%0d: b_valid=%b b_data=%h, need 1/%h", i, b_valid, b_data, 8'(i));
            end
            tick();
        end
        #1;
        n_tests++;
        if (b_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: b_valid=%b count=%0d, need 0/0", b_valid, count);
        end
    endtask

    task automatic test_concurrent();
        b_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_data = 8'($urandom);
            tick();
        end
        a_data = 8'hAA; b_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            #1;
            n_tests++;
            if (b_valid !== 1'b1 || b_data !== q[0] || count !== 3'd3 || a_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL push_pop_%0d: b_valid=%b b_data=%h count=%0d a_ready=%b, need 1/%h/3/1",
                         i, b_valid, b_data, count, a_ready, q[0]);
            end
            tick();
            a_data = 8'($urandom);
        end
        a_valid = 1'b0;
    endtask

    task automatic test_flush();
        a_valid = 1'b0; b_ready = 1'b1;
        tick();
        #1;
        n_tests++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_setup: count=%0d, need 2", count);
        end
        flush = 1'b1; a_valid = 1'b1; a_data = 8'h77;
        #1;
        n_tests++;
        if (a_ready !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_handshake: a_ready=%b b_valid=%b, need 0/0", a_ready, b_valid);
        end
        tick();
        flush = 1'b0; a_valid = 1'b0;
        #1;
        n_tests++;
        if (count !== 3'd0 || ovf_err !== m_ovf || ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_result: count=%0d ovf=%b, need 0/%b", count, ovf_err, m_ovf);
        end
        b_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_valid = 1'b1; a_data = 8'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; a_valid = 1'b0;
        #1;
        n_tests++;
        if (count !== 3'd0 || ovf_err !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d ovf=%b b_valid=%b, need 0/0/0", count, ovf_err, b_valid);
        end
    endtask

    task automatic test_random();
        logic       e_ar;
        logic       e_bv;
        logic [7:0] e_bd;
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            flush   = ($urandom_range(0, 29) == 0);
            a_valid = ($urandom_range(0, 99) < 60);
            b_ready = ($urandom_range(0, 99) < 50);
            a_data  = 8'($urandom);
            #1;
            e_ar = (q.size() != 4) && !flush;
            e_bv = !flush && (q.size() != 0 || a_valid);
            e_bd = (q.size() != 0) ? q[0] : a_data;
            n_tests++;
            if (a_ready !== e_ar || b_valid !== e_bv || (e_bv && b_data !== e_bd)) begin
                n_fail++;
                $display("FAIL rand_out_%0d: a_ready=%b b_valid=%b b_data=%h, need %b/%b/%h",
                         i, a_ready, b_valid, b_data, e_ar, e_bv, e_bd);
            end
            n_tests++;
            if (count !== 3'(q.size()) || a_almost_full !== (q.size() >= 3) || ovf_err !== m_ovf) begin
                n_fail++;
                $display("FAIL rand_state_%0d: count=%0d afull=%b ovf=%b, need %0d/%b/%b",
                         i, count, a_almost_full, ovf_err, q.size(), (q.size() >= 3), m_ovf);
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0; a_valid = 1'b0; b_ready = 1'b0;
    endtask

    task automatic test_no_bypass();
        n_a_valid = 1'b1; n_a_data = 8'h5A; n_b_ready = 1'b1;
        #1;
        n_tests++;
        if (n_b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nobyp_same_cycle: b_valid=%b, need 0", n_b_valid);
        end
        tick();
        n_a_valid = 1'b0;
        #1;
        n_tests++;
        if (n_b_valid !== 1'b1 || n_b_data !== 8'h5A || n_count !== 3'd1) begin
            n_fail++;
            $display("FAIL nobyp_next_cycle: b_valid=%b b_data=%h count=%0d, need 1/5a/1", n_b_valid, n_b_data, n_count);
        end
        tick();
        #1;
        n_tests++;
        if (n_b_valid !== 1'b0 || n_count !== 3'd0) begin
            n_fail++;
            $display("FAIL nobyp_drained: b_valid=%b count=%0d, need 0/0", n_b_valid, n_count);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; a_valid = 1'b0; a_data = '0; b_ready = 1'b0;
        n_a_valid = 1'b0; n_a_data = '0; n_b_ready = 1'b0;
        m_ovf = 1'b0;
        test_reset();
        test_bypass();
        test_fill_ovf();
        test_drain();
        test_concurrent();
        test_flush();
        test_random();
        test_no_bypass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
